ex_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle EX-stage unit for the RV M-extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/ex_muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Purpose     : iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the EX ALU.
// Latency     : XLEN+1 cycles from accept to valid_o; divide-by-zero / signed overflow resolve in 1 cycle.
// Backpressure: ready_o only in IDLE; the result is held in DONE until ready_i, then the unit returns to IDLE.
//
// Ports:
//   clk, rst (sync, active-high), flush_i (kills in-flight op, blocks a same-cycle accept)
//   upstream  : valid_i / ready_o, op_i, r1_data_i, r2_data_i, w_enable_i, w_addr_i
//   downstream: valid_o / ready_i, w_enable_o (qualified by valid_o), w_addr_o, w_data_o
module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       r1_data_i,
    input  logic [XLEN-1:0]       r2_data_i,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [XLEN-1:0]       w_data_o
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            op_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       b_q;       // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*XLEN-1:0]     acc_q;     // {partial hi, multiplier} or {remainder, dividend/quotient}
    logic                  s1_q, s2_q;
    logic [CW-1:0]         cnt_q;
    logic [XLEN-1:0]       res_q;

    // ---------------- accept-side decode ----------------
    logic            is_div, sgn1, sgn2, s1_in, s2_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept, last;

    always_comb begin
        is_div   = op_i[2];
        sgn1     = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
        sgn2     = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
        s1_in    = sgn1 & r1_data_i[XLEN-1];
        s2_in    = sgn2 & r2_data_i[XLEN-1];
        a_mag    = s1_in ? -r1_data_i : r1_data_i;
        b_mag    = s2_in ? -r2_data_i : r2_data_i;
        div_zero = is_div && (r2_data_i == '0);
        div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (r1_data_i == MIN_INT) && (r2_data_i == '1);
        special  = div_zero | div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? r1_data_i : '1;   // REM/REMU return dividend
        else if (div_ovf)
            special_res = op_i[1] ? '0 : MIN_INT;
    end

    assign accept = valid_i & ready_o & ~flush_i;
    assign last   = (cnt_q == CW'(XLEN - 1));

    // ---------------- one iteration of either datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        // shift-add: add multiplicand into the high half when the current multiplier bit is set,
        // then shift the whole accumulator right (carry enters the top)
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
        // restoring divide: the shifted remainder needs XLEN+1 bits before the trial subtract
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        div_nxt   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_nxt   = op_q[2] ? div_nxt : mul_nxt;

        prod = (s1_q ^ s2_q) ? -acc_nxt : acc_nxt;
        quo  = (s1_q ^ s2_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = s1_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo;
            default:                      final_res = rem;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_CALC;
                S_CALC:  if (last)   state_nxt = S_DONE;
                S_DONE:  if (ready_i) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o    = (state == S_IDLE);
        valid_o    = (state == S_DONE);
        w_enable_o = wen_q & (state == S_DONE);
        w_addr_o   = addr_q;
        w_data_o   = res_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            op_q   <= op_i;
            wen_q  <= w_enable_i;
            addr_q <= w_addr_i;
            s1_q   <= s1_in;
            s2_q   <= s2_in;
            b_q    <= is_div ? b_mag : a_mag;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt_q  <= '0;
            if (special) res_q <= special_res;
        end else if (state == S_CALC) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) res_q <= final_res;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst, flush_i, valid_i, ready_o, ready_i, valid_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] r1_data_i, r2_data_i, w_data_o;
    logic            w_enable_i, w_enable_o;
    logic [AW-1:0]   w_addr_i, w_addr_o;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
        .w_enable_i(w_enable_i), .w_addr_i(w_addr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o)
    );

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic          wen;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   hs_cyc = -1;
    logic prev_valid = 1'b0;
    logic busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            busy       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (busy) chk("ready_o_low_while_busy", 32'(ready_o), 32'd0);
            if (valid_o) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got data 0x%08h expected no result", w_data_o);
                    end else begin
                        cur = sb.pop_front();
                        chk("w_data_o", w_data_o, cur.data);
                        chk("w_addr_o", 32'(w_addr_o), 32'(cur.addr));
                        chk("w_enable_o", 32'(w_enable_o), 32'(cur.wen));
                        chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
                    end
                end else begin
                    chk("hold_w_data_o", w_data_o, cur.data);
                    chk("hold_w_addr_o", 32'(w_addr_o), 32'(cur.addr));
                end
                if (ready_i) begin
                    hs_cyc = cyc;
                    busy   = 1'b0;
                end
            end
            if (flush_i) busy = 1'b0;
            if (valid_i && ready_o && !flush_i) begin
                acc_cyc = cyc;
                busy    = 1'b1;
            end
            prev_valid = valid_o;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wen, input logic [AW-1:0] addr,
                         input bit push, input logic [31:0] exp, input int lat);
        exp_t e;
        int   n;
        if (push) begin
            e.data = exp; e.addr = addr; e.wen = wen; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b1; op_i = op; r1_data_i = a; r2_data_i = b;
        w_enable_i = wen; w_addr_i = addr;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o && !flush_i) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, n);
                break;
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL result_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_o"}, 32'(ready_o), 32'd1);
        chk({tag, "_valid_o"}, 32'(valid_o), 32'd0);
        chk({tag, "_w_enable_o"}, 32'(w_enable_o), 32'd0);
        chk({tag, "_w_addr_o"}, 32'(w_addr_o), 32'd0);
        chk({tag, "_w_data_o"}, w_data_o, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33},  // MUL
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33},  // MULH
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},  // MULHU
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},  // MULHSU
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},  // DIV -7/2
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},  // REM -7%2
        '{3'd5, 32'd100,      32'd7,        32'd14,       33},  // DIVU
        '{3'd7, 32'd100,      32'd7,        32'd2,        33},  // REMU
        '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1},   // DIV by zero
        '{3'd6, 32'd5,        32'd0,        32'd5,        1},   // REM by zero
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},   // DIV overflow
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},   // REM overflow
        '{3'd5, 32'd9,        32'd0,        32'hFFFFFFFF, 1},   // DIVU by zero
        '{3'd7, 32'd9,        32'd0,        32'd9,        1}    // REMU by zero
    };

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = '0; r1_data_i = '0; r2_data_i = '0; w_enable_i = 1'b0; w_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed vectors; the third one runs with write enable cleared
        for (int i = 0; i < 14; i++)
            issue(vecs[i].op, vecs[i].a, vecs[i].b, (i != 2), AW'(i + 1), 1'b1,
                  vecs[i].exp, vecs[i].lat);
        drain();

        // Backpressure: result held 5 cycles while a new op waits upstream
        ready_i = 1'b0;
        issue(3'd3, 32'h00010000, 32'h00010000, 1'b1, 5'd20, 1'b1, 32'h00000001, 33);
        fork
            issue(3'd5, 32'd100, 32'd7, 1'b1, 5'd21, 1'b1, 32'd14, 33);
            begin
                n = 0;
                while (!valid_o && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("bp_valid_o_held", 32'(valid_o), 32'd1);
                    chk("bp_ready_o_low", 32'(ready_o), 32'd0);
                end
                @(posedge clk); #1;
                ready_i = 1'b1;
            end
        join
        chk("bp_accept_after_handshake", 32'(acc_cyc), 32'(hs_cyc + 1));
        drain();

        // Flush 10 cycles into a DIVU, then a flush coinciding with a new op in IDLE
        issue(3'd5, 32'd1000, 32'd3, 1'b1, 5'd22, 1'b0, 32'd0, 0);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush_valid_o", 32'(valid_o), 32'd0);
        chk("flush_ready_o", 32'(ready_o), 32'd1);
        chk("flush_w_enable_o", 32'(w_enable_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b1; valid_i = 1'b1; op_i = 3'd0; r1_data_i = 32'd1; r2_data_i = 32'd1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("flush_blocks_accept", 32'(ready_o), 32'd1);
        issue(3'd0, 32'd3, 32'd4, 1'b1, 5'd23, 1'b1, 32'd12, 33);
        drain();

        // Same sequence with a mid-operation reset
        issue(3'd5, 32'd1000, 32'd3, 1'b1, 5'd24, 1'b0, 32'd0, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 1'b1, 5'd25, 1'b1, 32'd12, 33);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
